// File: rtl/jpeg_pkg.sv
// Shared types and constants for the RGB-to-YCbCr block scheduling path.
package jpeg_pkg;

    localparam int unsigned BLOCK_PIXELS = 64;
    localparam int unsigned CONV_LATENCY = 3;

    typedef logic [23:0] rgb_t;
    typedef logic [23:0] ycc_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } sched_state_e;

    typedef struct packed {
        logic sob;
        logic eob;
    } blk_tag_t;

    typedef struct packed {
        blk_tag_t tag;
        ycc_t     ycc;
    } fifo_word_t;

endpackage

// File: rtl/ycc_out_fifo.sv
// Synchronous output FIFO holding converter results with their block tags.
module ycc_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop & (count != '0);
    assign head   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Push is never gated: the upstream credit rule keeps it from overflowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ycc_block_scheduler.sv
// Feeds one 8x8 block at a time through the external RGB-to-YCbCr converter,
// tracking in-flight pixels with tokens and buffering tagged results.
module ycc_block_scheduler #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned BLOCK_PIXELS = jpeg_pkg::BLOCK_PIXELS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_rgb,
    output logic        conv_enable,
    output logic [23:0] conv_data_in,
    input  logic [23:0] conv_data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_ycc,
    output logic        out_sob,
    output logic        out_eob,
    output logic        busy
);
    import jpeg_pkg::*;

    localparam int unsigned PIX_W = $clog2(BLOCK_PIXELS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 2;

    sched_state_e                    state;
    logic [PIX_W-1:0]                pix_cnt;
    logic [CONV_LATENCY-1:0]         vld;
    blk_tag_t [CONV_LATENCY-1:0]     tag;
    blk_tag_t                        new_tag;
    logic [CNT_W-1:0]                fifo_count;
    logic [CRD_W-1:0]                credit_used;
    logic                            run;
    logic                            accept;
    logic                            last_px;
    fifo_word_t                      fifo_head;

    // Held low through reset and for one edge after, so in_ready reads 0 while reset is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign credit_used  = CRD_W'(fifo_count) + CRD_W'($countones(vld));
    assign in_ready     = run & (state != DRAIN) & (credit_used < CRD_W'(FIFO_DEPTH));
    assign accept       = in_valid & in_ready;
    assign last_px      = (pix_cnt == PIX_W'(BLOCK_PIXELS - 1));
    assign conv_enable  = accept | (|vld[CONV_LATENCY-2:0]);
    assign conv_data_in = accept ? in_rgb : '0;
    assign new_tag      = '{sob: (pix_cnt == '0), eob: last_px};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            tag <= '0;
        end else if (conv_enable) begin
            vld <= {vld[CONV_LATENCY-2:0], accept};
            tag <= {tag[CONV_LATENCY-2:0], new_tag};
        end else begin
            vld[CONV_LATENCY-1] <= 1'b0;
        end
    end

    // DRAIN exits once only the final token remains: it leaves the pipe on this edge,
    // so in_ready reopens exactly as the last pixel lands in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pix_cnt <= '0;
        end else begin
            if (accept) begin
                pix_cnt <= last_px ? '0 : pix_cnt + PIX_W'(1);
            end
            case (state)
                IDLE:    if (accept) state <= last_px ? DRAIN : FEED;
                FEED:    if (accept && last_px) state <= DRAIN;
                DRAIN:   if (vld[CONV_LATENCY-2:0] == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ycc_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_word_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld[CONV_LATENCY-1]),
        .push_data ({tag[CONV_LATENCY-1], conv_data_out}),
        .pop       (out_ready),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_ycc   = fifo_head.ycc;
    assign out_sob   = fifo_head.tag.sob;
    assign out_eob   = fifo_head.tag.eob;
    assign busy      = (state != IDLE) | (fifo_count != '0);

endmodule
